serial_word_shifter: RTL



---
 rtl/serial_word_shifter.sv | 112 +++++++++++
 1 files changed

// File: rtl/serial_word_shifter.sv
// Parallel-to-serial feeder: accepts words over valid/ready and shifts them out one bit per clock.
// A one-word pending buffer lets consecutive words stream without a bubble.
module serial_word_shifter #(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 dout,
  output logic                 dout_valid,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] words_sent
);

  localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WIDTH - 1);
  localparam logic [3:0]      GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t          state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] pend;
  logic             pend_full;
  logic [BC_W-1:0]  bitcnt;
  logic [3:0]       gapcnt;

  logic             accept;
  logic             last_bit;
  logic             gap_done;
  logic             load;
  logic [WIDTH-1:0] next_word;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // The pending word always has priority over a word offered on the same edge.
  always_comb begin
    accept    = data_valid && !pend_full;
    last_bit  = (state == SHIFT) && (bitcnt == BIT_LAST);
    gap_done  = (state == GAP) && (gapcnt == GAP_LAST);
    next_word = pend_full ? pend : data_in;
    load      = (pend_full || accept) &&
                ((state == IDLE) || gap_done || (last_bit && (GAP_CYCLES == 0)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      bitcnt     <= '0;
      gapcnt     <= '0;
      words_sent <= '0;
    end else begin
      if (accept && !load) begin
        pend      <= data_in;
        pend_full <= 1'b1;
      end else if (load) begin
        pend_full <= 1'b0;
      end

      if (load) begin
        shreg  <= next_word;
        bitcnt <= '0;
      end else if (state == SHIFT) begin
        shreg  <= advance(shreg);
        bitcnt <= bitcnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (load) state <= SHIFT;
        end
        SHIFT: begin
          if (last_bit) begin
            words_sent <= words_sent + CNT_WIDTH'(1);
            if (GAP_CYCLES > 0) begin
              state  <= GAP;
              gapcnt <= '0;
            end else if (!load) begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_done) state <= load ? SHIFT : IDLE;
          else          gapcnt <= gapcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data_ready = !pend_full;
  assign dout       = (state == SHIFT) ? head_bit(shreg) : IDLE_LEVEL;
  assign dout_valid = (state == SHIFT);
  assign busy       = (state != IDLE) || pend_full;

endmodule
